// File: rtl/bram_dual_arbiter_if.sv
// Client-side and RAM-side signal bundle for bram_dual_arbiter.
// Handshake: a client holds REQ/ADDR/DATA until it sees its GNT high; the GNT cycle is the transfer.

interface bram_dual_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  WR_REQ_0;
    logic                  WR_REQ_1;
    logic [ADDR_WIDTH-1:0] WR_ADDR_0;
    logic [ADDR_WIDTH-1:0] WR_ADDR_1;
    logic [DATA_WIDTH-1:0] WR_DATA_0;
    logic [DATA_WIDTH-1:0] WR_DATA_1;
    logic                  WR_GNT_0;
    logic                  WR_GNT_1;
    logic                  RD_REQ_0;
    logic                  RD_REQ_1;
    logic [ADDR_WIDTH-1:0] RD_ADDR_0;
    logic [ADDR_WIDTH-1:0] RD_ADDR_1;
    logic                  RD_GNT_0;
    logic                  RD_GNT_1;
    logic                  RD_VALID_0;
    logic                  RD_VALID_1;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RAM_WE;
    logic [ADDR_WIDTH-1:0] RAM_WR_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DI;
    logic [ADDR_WIDTH-1:0] RAM_RD_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DO;

    modport slave (
        input  WR_REQ_0, WR_REQ_1, WR_ADDR_0, WR_ADDR_1, WR_DATA_0, WR_DATA_1,
        input  RD_REQ_0, RD_REQ_1, RD_ADDR_0, RD_ADDR_1, RAM_DO,
        output WR_GNT_0, WR_GNT_1, RD_GNT_0, RD_GNT_1, RD_VALID_0, RD_VALID_1, RD_DATA,
        output RAM_WE, RAM_WR_ADDR, RAM_DI, RAM_RD_ADDR
    );

    modport master (
        output WR_REQ_0, WR_REQ_1, WR_ADDR_0, WR_ADDR_1, WR_DATA_0, WR_DATA_1,
        output RD_REQ_0, RD_REQ_1, RD_ADDR_0, RD_ADDR_1, RAM_DO,
        input  WR_GNT_0, WR_GNT_1, RD_GNT_0, RD_GNT_1, RD_VALID_0, RD_VALID_1, RD_DATA,
        input  RAM_WE, RAM_WR_ADDR, RAM_DI, RAM_RD_ADDR
    );
endinterface

// File: rtl/bram_dual_arbiter.sv
// Two-client round-robin arbitration of one BRAM write port and one registered read port,
// with tagged read responses and write-to-read forwarding on same-address collisions.

module bram_dual_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input logic                 CLK,
    input logic                 RESET,
    bram_dual_arbiter_if.slave  bus
);

    logic                  wr_pri;
    logic                  rd_pri;
    logic                  rd_valid_0;
    logic                  rd_valid_1;
    logic                  byp;
    logic [DATA_WIDTH-1:0] byp_data;

    logic                  wr_gnt_0;
    logic                  wr_gnt_1;
    logic                  rd_gnt_0;
    logic                  rd_gnt_1;
    logic                  wr_any;
    logic                  rd_any;
    logic                  collide;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // A lone requester always wins; on contention the priority bit picks the client.
    always_comb begin
        wr_gnt_0 = !RESET && bus.WR_REQ_0 && (!bus.WR_REQ_1 || !wr_pri);
        wr_gnt_1 = !RESET && bus.WR_REQ_1 && (!bus.WR_REQ_0 || wr_pri);
        rd_gnt_0 = !RESET && bus.RD_REQ_0 && (!bus.RD_REQ_1 || !rd_pri);
        rd_gnt_1 = !RESET && bus.RD_REQ_1 && (!bus.RD_REQ_0 || rd_pri);
        wr_any   = wr_gnt_0 || wr_gnt_1;
        rd_any   = rd_gnt_0 || rd_gnt_1;
        wr_addr  = wr_gnt_1 ? bus.WR_ADDR_1 : bus.WR_ADDR_0;
        wr_data  = wr_gnt_1 ? bus.WR_DATA_1 : bus.WR_DATA_0;
        rd_addr  = rd_gnt_1 ? bus.RD_ADDR_1 : bus.RD_ADDR_0;
        collide  = wr_any && rd_any && (rd_addr == wr_addr);
    end

    assign bus.WR_GNT_0    = wr_gnt_0;
    assign bus.WR_GNT_1    = wr_gnt_1;
    assign bus.RD_GNT_0    = rd_gnt_0;
    assign bus.RD_GNT_1    = rd_gnt_1;
    assign bus.RAM_WE      = wr_any;
    assign bus.RAM_WR_ADDR = wr_addr;
    assign bus.RAM_DI      = wr_data;
    assign bus.RAM_RD_ADDR = rd_addr;
    assign bus.RD_VALID_0  = rd_valid_0;
    assign bus.RD_VALID_1  = rd_valid_1;
    // The RAM output is undefined after a same-address read-during-write, so substitute the write data.
    assign bus.RD_DATA     = byp ? byp_data : bus.RAM_DO;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_pri     <= 1'b0;
            rd_pri     <= 1'b0;
            rd_valid_0 <= 1'b0;
            rd_valid_1 <= 1'b0;
            byp        <= 1'b0;
        end else begin
            // Priority moves to whichever client just lost (or did not ask).
            if (wr_any) wr_pri <= wr_gnt_0;
            if (rd_any) rd_pri <= rd_gnt_0;
            rd_valid_0 <= rd_gnt_0;
            rd_valid_1 <= rd_gnt_1;
            byp        <= collide;
            if (collide) byp_data <= wr_data;
        end
    end

endmodule

// File: tb/tb_bram_dual_arbiter.sv
// Self-checking bench for bram_dual_arbiter: behavioural BRAM, rule-level reference model,
// directed scenarios followed by randomized contention with ready-style request holding.

module tb_bram_dual_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [DW-1:0] POISON = 32'hBADC0FFE;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    bram_dual_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_dual_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 32'h11111111;
        return 32'h9E3779B1 * i + 32'h1234;
    endfunction

    // Behavioural BRAM: registered read, garbage on same-address read-during-write.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          ram_init_done = 1'b0;
    always @(posedge CLK) begin
        if (!ram_init_done) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
            ram_init_done <= 1'b1;
        end else begin
            if (bus.RAM_WE) ram[bus.RAM_WR_ADDR] <= bus.RAM_DI;
            bus.RAM_DO <= (bus.RAM_WE && bus.RAM_WR_ADDR == bus.RAM_RD_ADDR) ? POISON : ram[bus.RAM_RD_ADDR];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          m_wr_last;
    logic          m_rd_last;
    logic [DW:0]   exp_q [$];

    logic [4:0]       obs_gnt, exp_gnt;   // {RAM_WE, WR_GNT_1, WR_GNT_0, RD_GNT_1, RD_GNT_0}
    logic [1:0]       obs_rv, exp_rv;     // {RD_VALID_1, RD_VALID_0}
    logic [DW-1:0]    obs_rd, exp_rd;
    logic [AW+DW-1:0] obs_wport, exp_wport;
    logic [AW-1:0]    obs_raddr, exp_raddr;

    task automatic set_idle();
        bus.WR_REQ_0 = 1'b0; bus.WR_REQ_1 = 1'b0;
        bus.RD_REQ_0 = 1'b0; bus.RD_REQ_1 = 1'b0;
        bus.WR_ADDR_0 = '0; bus.WR_ADDR_1 = '0;
        bus.WR_DATA_0 = '0; bus.WR_DATA_1 = '0;
        bus.RD_ADDR_0 = '0; bus.RD_ADDR_1 = '0;
    endtask

    // Winner under the rules: lone requester wins, contention goes to the client that did not win last.
    task automatic pick(input logic r0, input logic r1, input logic last, output logic g0, output logic g1);
        g0 = 1'b0; g1 = 1'b0;
        if (!RESET) begin
            if (r0 && r1) begin
                if (last) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = r0; g1 = r1;
            end
        end
    endtask

    // Samples one cycle's DUT outputs, computes the model's expectations, then advances the clock.
    task automatic run_cycle();
        logic [DW:0] ent;
        logic wg0, wg1, rg0, rg1;
        #1;
        obs_gnt   = {bus.RAM_WE, bus.WR_GNT_1, bus.WR_GNT_0, bus.RD_GNT_1, bus.RD_GNT_0};
        obs_rv    = {bus.RD_VALID_1, bus.RD_VALID_0};
        obs_rd    = bus.RD_DATA;
        obs_wport = {bus.RAM_WR_ADDR, bus.RAM_DI};
        obs_raddr = bus.RAM_RD_ADDR;
        exp_rv = 2'b00;
        exp_rd = '0;
        if (exp_q.size() > 0) begin
            ent    = exp_q.pop_front();
            exp_rv = ent[DW] ? 2'b10 : 2'b01;
            exp_rd = ent[DW-1:0];
        end
        pick(bus.WR_REQ_0, bus.WR_REQ_1, m_wr_last, wg0, wg1);
        pick(bus.RD_REQ_0, bus.RD_REQ_1, m_rd_last, rg0, rg1);
        exp_gnt   = {wg0 | wg1, wg1, wg0, rg1, rg0};
        exp_wport = wg1 ? {bus.WR_ADDR_1, bus.WR_DATA_1} : {bus.WR_ADDR_0, bus.WR_DATA_0};
        exp_raddr = rg1 ? bus.RD_ADDR_1 : bus.RD_ADDR_0;
        if (RESET) begin
            m_wr_last = 1'b1;
            m_rd_last = 1'b1;
        end else begin
            if (wg0 || wg1) begin
                ref_mem[exp_wport[DW +: AW]] = exp_wport[DW-1:0];
                m_wr_last = wg1;
            end
            if (rg0 || rg1) begin
                exp_q.push_back({rg1, ref_mem[exp_raddr]});
                m_rd_last = rg1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.WR_REQ_0 = 1'b1; bus.WR_REQ_1 = 1'b1; bus.RD_REQ_0 = 1'b1; bus.RD_REQ_1 = 1'b1;
        bus.WR_ADDR_0 = 10'h010; bus.WR_ADDR_1 = 10'h011;
        bus.WR_DATA_0 = 32'hC0C0_0000; bus.WR_DATA_1 = 32'hC1C1_0001;
        bus.RD_ADDR_0 = 10'h012; bus.RD_ADDR_1 = 10'h013;
        for (int k = 0; k < 2; k++) begin
            run_cycle();
            checks++;
            if (obs_gnt !== 5'b00000) begin errors++; $display("FAIL reset_gnt: got %b want 00000", obs_gnt); end
            checks++;
            if (obs_rv !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", obs_rv); end
        end
        RESET = 1'b0;
        run_cycle();
        checks++;
        if (obs_gnt !== 5'b10101) begin errors++; $display("FAIL reset_release_gnt: got %b want 10101", obs_gnt); end
        checks++;
        if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL reset_release_model: got %b want %b", obs_gnt, exp_gnt); end
        set_idle();
        run_cycle();
        checks++;
        if (obs_rv !== 2'b01 || obs_rd !== init_val(12'h012)) begin
            errors++; $display("FAIL reset_first_rsp: got %b/%h want 01/%h", obs_rv, obs_rd, init_val(12'h012));
        end
    endtask

    task automatic test_contention();
        bus.WR_REQ_0 = 1'b1; bus.WR_REQ_1 = 1'b1; bus.RD_REQ_0 = 1'b1; bus.RD_REQ_1 = 1'b1;
        bus.RD_ADDR_0 = 10'h030; bus.RD_ADDR_1 = 10'h031;
        for (int k = 0; k < 8; k++) begin
            bus.WR_ADDR_0 = 10'h020; bus.WR_ADDR_1 = 10'h021;
            bus.WR_DATA_0 = $urandom; bus.WR_DATA_1 = $urandom;
            run_cycle();
            checks++;
            if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", k, obs_gnt, exp_gnt); end
            checks++;
            if (obs_rv !== exp_rv) begin errors++; $display("FAIL contention_valid[%0d]: got %b want %b", k, obs_rv, exp_rv); end
            if (exp_rv != 2'b00) begin
                checks++;
                if (obs_rd !== exp_rd) begin errors++; $display("FAIL contention_data[%0d]: got %h want %h", k, obs_rd, exp_rd); end
            end
        end
        set_idle();
        run_cycle();
        checks++;
        if (obs_rv !== exp_rv || obs_rd !== exp_rd) begin
            errors++; $display("FAIL contention_drain: got %b/%h want %b/%h", obs_rv, obs_rd, exp_rv, exp_rd);
        end
    endtask

    task automatic test_forwarding();
        set_idle();
        bus.WR_REQ_0 = 1'b1; bus.WR_ADDR_0 = 10'h005; bus.WR_DATA_0 = 32'hDEADBEEF;
        bus.RD_REQ_1 = 1'b1; bus.RD_ADDR_1 = 10'h005;
        run_cycle();
        checks++;
        if (obs_gnt !== 5'b10110) begin errors++; $display("FAIL fwd_gnt: got %b want 10110", obs_gnt); end
        bus.WR_REQ_0 = 1'b0;
        run_cycle();
        checks++;
        if (obs_rv !== 2'b10 || obs_rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fwd_collision_rsp: got %b/%h want 10/deadbeef", obs_rv, obs_rd);
        end
        set_idle();
        run_cycle();
        checks++;
        if (obs_rv !== 2'b10 || obs_rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fwd_reread_rsp: got %b/%h want 10/deadbeef", obs_rv, obs_rd);
        end
    endtask

    task automatic test_write_then_read();
        set_idle();
        bus.WR_REQ_1 = 1'b1; bus.WR_ADDR_1 = 10'h3FF; bus.WR_DATA_1 = 32'hA5A5A5A5;
        run_cycle();
        checks++;
        if (obs_gnt !== 5'b11000) begin errors++; $display("FAIL wtr_wr_gnt: got %b want 11000", obs_gnt); end
        set_idle();
        bus.RD_REQ_0 = 1'b1; bus.RD_ADDR_0 = 10'h3FF;
        run_cycle();
        bus.RD_ADDR_0 = 10'h000;
        run_cycle();
        checks++;
        if (obs_rv !== 2'b01 || obs_rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL wtr_rsp: got %b/%h want 01/a5a5a5a5", obs_rv, obs_rd);
        end
        set_idle();
        run_cycle();
        checks++;
        if (obs_rv !== 2'b01 || obs_rd !== 32'h00001234) begin
            errors++; $display("FAIL wtr_unwritten: got %b/%h want 01/00001234", obs_rv, obs_rd);
        end
    endtask

    task automatic test_single_requester();
        set_idle();
        bus.RD_REQ_1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) bus.RD_REQ_1 = 1'b0;
            bus.RD_ADDR_1 = AW'(k);
            run_cycle();
            if (k < 8) begin
                checks++;
                if (obs_gnt !== 5'b00010) begin errors++; $display("FAIL single_gnt[%0d]: got %b want 00010", k, obs_gnt); end
            end
            if (k > 0) begin
                checks++;
                if (obs_rv !== 2'b10 || obs_rd !== ref_mem[k-1]) begin
                    errors++; $display("FAIL single_rsp[%0d]: got %b/%h want 10/%h", k, obs_rv, obs_rd, ref_mem[k-1]);
                end
            end
        end
        run_cycle();
        checks++;
        if (obs_rv !== 2'b00) begin errors++; $display("FAIL single_tail: got %b want 00", obs_rv); end
    endtask

    task automatic test_mid_reset();
        set_idle();
        bus.WR_REQ_0 = 1'b1; bus.WR_ADDR_0 = 10'h040; bus.WR_DATA_0 = 32'h0F0F0F0F;
        bus.RD_REQ_0 = 1'b1; bus.RD_ADDR_0 = 10'h009;
        run_cycle();
        RESET = 1'b1;
        bus.WR_REQ_1 = 1'b1; bus.RD_REQ_1 = 1'b1;
        bus.WR_ADDR_1 = 10'h041; bus.RD_ADDR_1 = 10'h042;
        run_cycle();
        checks++;
        if (obs_rv !== 2'b01 || obs_rd !== init_val(9)) begin
            errors++; $display("FAIL midreset_rsp: got %b/%h want 01/%h", obs_rv, obs_rd, init_val(9));
        end
        checks++;
        if (obs_gnt !== 5'b00000) begin errors++; $display("FAIL midreset_gnt: got %b want 00000", obs_gnt); end
        RESET = 1'b0;
        run_cycle();
        checks++;
        if (obs_gnt !== 5'b10101) begin errors++; $display("FAIL midreset_release_gnt: got %b want 10101", obs_gnt); end
        checks++;
        if (obs_rv !== 2'b00) begin errors++; $display("FAIL midreset_no_rsp: got %b want 00", obs_rv); end
        set_idle();
        run_cycle();
        checks++;
        if (obs_rv !== 2'b01 || obs_rd !== init_val(9)) begin
            errors++; $display("FAIL midreset_after: got %b/%h want 01/%h", obs_rv, obs_rd, init_val(9));
        end
    endtask

    task automatic test_random();
        set_idle();
        for (int k = 0; k < 400; k++) begin
            // A client whose request was not granted keeps it unchanged.
            if (!(bus.WR_REQ_0 && !exp_gnt[2])) begin
                bus.WR_REQ_0 = ($urandom_range(0, 3) != 0);
                bus.WR_ADDR_0 = AW'($urandom_range(0, 15)); bus.WR_DATA_0 = $urandom;
            end
            if (!(bus.WR_REQ_1 && !exp_gnt[3])) begin
                bus.WR_REQ_1 = ($urandom_range(0, 3) != 0);
                bus.WR_ADDR_1 = AW'($urandom_range(0, 15)); bus.WR_DATA_1 = $urandom;
            end
            if (!(bus.RD_REQ_0 && !exp_gnt[0])) begin
                bus.RD_REQ_0 = ($urandom_range(0, 3) != 0);
                bus.RD_ADDR_0 = AW'($urandom_range(0, 15));
            end
            if (!(bus.RD_REQ_1 && !exp_gnt[1])) begin
                bus.RD_REQ_1 = ($urandom_range(0, 3) != 0);
                bus.RD_ADDR_1 = AW'($urandom_range(0, 15));
            end
            run_cycle();
            checks++;
            if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", k, obs_gnt, exp_gnt); end
            checks++;
            if (obs_rv !== exp_rv) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", k, obs_rv, exp_rv); end
            if (exp_rv != 2'b00) begin
                checks++;
                if (obs_rd !== exp_rd) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", k, obs_rd, exp_rd); end
            end
            if (exp_gnt[4]) begin
                checks++;
                if (obs_wport !== exp_wport) begin errors++; $display("FAIL rand_wport[%0d]: got %h want %h", k, obs_wport, exp_wport); end
            end
            if (exp_gnt[1:0] != 2'b00) begin
                checks++;
                if (obs_raddr !== exp_raddr) begin errors++; $display("FAIL rand_raddr[%0d]: got %h want %h", k, obs_raddr, exp_raddr); end
            end
        end
        set_idle();
        run_cycle();
        checks++;
        if (obs_rv !== exp_rv || (exp_rv != 2'b00 && obs_rd !== exp_rd)) begin
            errors++; $display("FAIL rand_drain: got %b/%h want %b/%h", obs_rv, obs_rd, exp_rv, exp_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
        m_wr_last = 1'b1;
        m_rd_last = 1'b1;
        exp_gnt   = '0;
        set_idle();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        test_reset();
        test_contention();
        test_forwarding();
        test_write_then_read();
        test_single_requester();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_dual_arbiter.md
# bram_dual_arbiter

Two-client arbiter and sequencer in front of one dual-port block RAM (one write port, one registered read port, 1-cycle read latency, data undefined on same-address read-during-write). Two clients share the RAM's write port and read port through independent round-robin arbiters. Read responses are tagged back to the issuing client. Same-address read/write collisions are resolved by forwarding, so a read always returns the value the RAM holds after the same-cycle write. The block sits between processor-side request logic and the RAM instance; it is the only master of that RAM.

## Interface
- ADDR_WIDTH, 10, RAM address width
- DATA_WIDTH, 32, RAM data width

- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- WR_REQ_0 / WR_REQ_1  in  1  client write request
- WR_ADDR_0 / WR_ADDR_1  in  ADDR_WIDTH  write address
- WR_DATA_0 / WR_DATA_1  in  DATA_WIDTH  write data
- WR_GNT_0 / WR_GNT_1  out  1  write accepted this cycle (combinational)
- RD_REQ_0 / RD_REQ_1  in  1  client read request
- RD_ADDR_0 / RD_ADDR_1  in  ADDR_WIDTH  read address
- RD_GNT_0 / RD_GNT_1  out  1  read accepted this cycle (combinational)
- RD_VALID_0 / RD_VALID_1  out  1  read response for that client (registered pulse)
- RD_DATA  out  DATA_WIDTH  read response data, shared, qualified by RD_VALID_x
- RAM_WE  out  1  RAM write enable
- RAM_WR_ADDR  out  ADDR_WIDTH  RAM write address
- RAM_DI  out  DATA_WIDTH  RAM write data
- RAM_RD_ADDR  out  ADDR_WIDTH  RAM read address
- RAM_DO  in  DATA_WIDTH  RAM read data (valid cycle after address)

## Operation
- State: WR_PRI (1 bit), RD_PRI (1 bit), RD_VALID_0/1, BYP (1 bit), BYP_DATA (DATA_WIDTH).
- Write arbiter: if exactly one WR_REQ, grant it. If both, grant client WR_PRI. On any grant, WR_PRI <= index of the non-granted client, i.e. !granted index. No request: WR_PRI unchanged.
- RAM_WE = WR_GNT_0 | WR_GNT_1. RAM_WR_ADDR/RAM_DI = granted client's address/data; client 0's when no grant.
- Read arbiter: identical policy with RD_PRI and RD_REQ; RAM_RD_ADDR = granted client's address, client 0's when idle.
- Response: RD_VALID_i <= RD_GNT_i; exactly one cycle high per grant; at most one RD_VALID high per cycle.
- Collision: BYP <= RAM_WE & read granted & (RAM_RD_ADDR == RAM_WR_ADDR); BYP_DATA <= RAM_DI when that condition holds.
- RD_DATA = BYP ? BYP_DATA : RAM_DO (never X when a response is valid).
- While RESET high: all GNT outputs and RAM_WE forced 0 combinationally; no RAM write occurs.
- At a rising edge with RESET high: WR_PRI=0, RD_PRI=0, RD_VALID_0/1=0, BYP=0. BYP_DATA is don't-care.
- Grants are ready-style: a client holds REQ/ADDR/DATA until its GNT is seen high; the arbiter never grants an unrequested client.

## Timing
- Write: granted in cycle t, RAM updated at edge ending t; a read granted in t+1 to the same address returns the new data.
- Read: granted in cycle t, RD_VALID_x and RD_DATA valid in cycle t+1. Full throughput: one read and one write per cycle.
- Same-cycle write and read to the same address: the read returns the written data in t+1.
- Reset mid-operation: a response already registered (RD_VALID high in the cycle RESET rises) is still presented that cycle. A grant cannot occur in a reset cycle, so no response follows it.
- Fairness: under continuous contention each client is granted every second cycle on each port.

## Test plan
- Reset: hold RESET 2 cycles with all REQs high -> all GNT=0, RAM_WE=0; the cycle after release both REQs high -> GNT_0 wins on both ports.
- Contention: both clients write continuously -> WR_GNT alternates 0,1,0,1. RD_REQ from both -> RD_VALID alternates 0,1,0,1, each one cycle after its grant.
- Forwarding: client 0 writes 0xDEADBEEF to 0x005 while client 1 reads 0x005 (old value 0x11111111) -> next cycle RD_VALID_1=1, RD_DATA=0xDEADBEEF. Repeat the read -> 0xDEADBEEF from RAM.
- Write-then-read: write 0xA5A5A5A5 to 0x3FF in t, read 0x3FF in t+1 -> RD_DATA=0xA5A5A5A5 in t+2. Read 0x000 unwritten after init -> RAM content.
- Single requester: only client 1 issues 8 back-to-back reads to 0..7 -> granted every cycle, 8 consecutive RD_VALID_1 pulses, data in address order. RD_VALID_0 stays 0.
- Mid-op reset: read granted in t, RESET high in t+1 -> RD_VALID pulse still seen in t+1. WR_PRI/RD_PRI return to 0 and client 0 wins the first contended cycle after release.
